// File: rtl/sigdelay_ctrl.sv
// Sequencer for the mic delay-line datapath: turns the per-sample strobe into
// counter/RAM controls and masks delayed output until enough history is stored.
module sigdelay_ctrl #(
  parameter int A_WIDTH = 9,
  parameter int D_WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic               sample_valid,
  input  logic               offset_load,
  input  logic [D_WIDTH-1:0] offset_in,
  output logic               en,
  output logic               wr,
  output logic               rd,
  output logic [D_WIDTH-1:0] incr,
  output logic [D_WIDTH-1:0] offset,
  output logic               out_valid,
  output logic               busy,
  output logic               missed
);

  localparam int CMP_W = (A_WIDTH + 1 > D_WIDTH) ? A_WIDTH + 1 : D_WIDTH;
  localparam logic [A_WIDTH:0] HIST_MAX = {1'b1, {A_WIDTH{1'b0}}};

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state;
  logic [A_WIDTH:0] hist;
  logic [A_WIDTH:0] hist_inc;
  logic [D_WIDTH-1:0] offset_new;
  logic             strobe_ok;

  // A zero delay would read the address being written in the same cycle.
  function automatic logic [D_WIDTH-1:0] clamp_offset(input logic [D_WIDTH-1:0] v);
    return (v == '0) ? D_WIDTH'(1) : v;
  endfunction

  function automatic logic [A_WIDTH:0] sat_inc(input logic [A_WIDTH:0] v);
    return (v == HIST_MAX) ? v : v + 1'b1;
  endfunction

  assign hist_inc   = sat_inc(hist);
  assign offset_new = clamp_offset(offset_in);
  assign strobe_ok  = sample_valid && !stop && !rst;
  assign incr       = D_WIDTH'(1);
  assign busy       = (state != IDLE);

  always_comb begin
    en = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    unique case (state)
      FILL: begin
        en = strobe_ok;
        wr = strobe_ok;
      end
      RUN: begin
        en = strobe_ok;
        wr = strobe_ok;
        rd = strobe_ok;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      offset    <= D_WIDTH'(1);
      hist      <= '0;
      out_valid <= 1'b0;
      missed    <= 1'b0;
    end else begin
      // RAM read data appears one cycle after rd
      out_valid <= rd;
      if (state == IDLE && sample_valid)
        missed <= 1'b1;
      if (offset_load)
        offset <= offset_new;
      if (wr)
        hist <= hist_inc;
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            state <= FILL;
            hist  <= '0;
          end
        end
        FILL: begin
          if (stop)
            state <= IDLE;
          else if (!offset_load && wr && CMP_W'(hist_inc) >= CMP_W'(offset))
            state <= RUN;
        end
        RUN: begin
          if (stop)
            state <= IDLE;
          else if (offset_load && CMP_W'(offset_new) > CMP_W'(hist))
            state <= FILL;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdelay_ctrl.sv
// Directed bench for sigdelay_ctrl: strobe sequences with hand-derived rd/out_valid.
module tb_sigdelay_ctrl;

  localparam int A_WIDTH = 9;
  localparam int D_WIDTH = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               stop;
  logic               sample_valid;
  logic               offset_load;
  logic [D_WIDTH-1:0] offset_in;
  logic               en;
  logic               wr;
  logic               rd;
  logic [D_WIDTH-1:0] incr;
  logic [D_WIDTH-1:0] offset;
  logic               out_valid;
  logic               busy;
  logic               missed;

  int checks = 0;
  int errors = 0;

  sigdelay_ctrl #(.A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .sample_valid (sample_valid),
    .offset_load  (offset_load),
    .offset_in    (offset_in),
    .en           (en),
    .wr           (wr),
    .rd           (rd),
    .incr         (incr),
    .offset       (offset),
    .out_valid    (out_valid),
    .busy         (busy),
    .missed       (missed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One sample strobe; rd and the following out_valid must both equal exp_rd.
  task automatic strobe(input logic exp_rd);
    @(negedge clk);
    sample_valid = 1'b1;
    #1;
    chk("en", 32'(en), 32'(1));
    chk("wr", 32'(wr), 32'(1));
    chk("rd", 32'(rd), 32'(exp_rd));
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 32'(exp_rd));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_offset(input logic [D_WIDTH-1:0] v, input logic with_start);
    @(negedge clk);
    offset_in   = v;
    offset_load = 1'b1;
    start       = with_start;
    @(posedge clk);
    #1;
    offset_load = 1'b0;
    start       = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
    offset_load = 1'b0; offset_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",      32'(busy),      32'(0));
    chk("rst_offset",    32'(offset),    32'(1));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_missed",    32'(missed),    32'(0));
    chk("rst_en",        32'(en),        32'(0));
    chk("rst_wr",        32'(wr),        32'(0));
    chk("rst_rd",        32'(rd),        32'(0));
    chk("rst_incr",      32'(incr),      32'(1));
    rst = 1'b0;

    // Offset 4 loaded together with start; rd only from the 5th strobe on
    load_offset(8'd4, 1'b1);
    chk("t1_busy",   32'(busy),   32'(1));
    chk("t1_offset", 32'(offset), 32'(4));
    for (int i = 0; i < 4; i++) strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    @(posedge clk);
    #1;
    chk("t1_ov_drop", 32'(out_valid), 32'(0));
    chk("t1_incr",    32'(incr),      32'(1));

    // hist 6 -> 10 in RUN, then raise delay to 20: back to FILL
    for (int i = 0; i < 4; i++) strobe(1'b1);
    load_offset(8'd20, 1'b0);
    chk("t2_offset20", 32'(offset), 32'(20));
    for (int i = 0; i < 10; i++) strobe(1'b0);
    strobe(1'b1);
    // hist 21, shrink delay to 3: stays in RUN
    load_offset(8'd3, 1'b0);
    chk("t2_offset3", 32'(offset), 32'(3));
    strobe(1'b1);

    // stop together with a strobe in RUN: nothing written
    @(negedge clk);
    stop = 1'b1;
    sample_valid = 1'b1;
    #1;
    chk("t5_stop_en", 32'(en), 32'(0));
    chk("t5_stop_wr", 32'(wr), 32'(0));
    chk("t5_stop_rd", 32'(rd), 32'(0));
    @(posedge clk);
    #1;
    stop = 1'b0;
    sample_valid = 1'b0;
    chk("t5_stop_busy", 32'(busy),      32'(0));
    chk("t5_stop_ov",   32'(out_valid), 32'(0));

    // Strobe while IDLE: dropped and flagged
    @(negedge clk);
    sample_valid = 1'b1;
    #1;
    chk("t5_idle_en", 32'(en), 32'(0));
    chk("t5_idle_wr", 32'(wr), 32'(0));
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    chk("t5_missed", 32'(missed), 32'(1));
    repeat (3) @(posedge clk);
    #1;
    chk("t5_missed_sticky", 32'(missed), 32'(1));

    // Zero delay clamps to 1; first strobe moves straight to RUN
    load_offset(8'd0, 1'b0);
    chk("t3_offset_clamp", 32'(offset), 32'(1));
    pulse_start();
    strobe(1'b0);
    strobe(1'b1);
    strobe(1'b1);
    chk("t3_missed_kept", 32'(missed), 32'(1));

    // Reset during RUN with a strobe pending
    @(negedge clk);
    rst = 1'b1;
    sample_valid = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sample_valid = 1'b0;
    chk("t6_busy",      32'(busy),      32'(0));
    chk("t6_offset",    32'(offset),    32'(1));
    chk("t6_out_valid", 32'(out_valid), 32'(0));
    chk("t6_missed",    32'(missed),    32'(0));

    // 600 strobes at delay 255: 255 fill strobes, then reads past hist saturation
    do_reset();
    load_offset(8'd255, 1'b1);
    chk("t4_offset", 32'(offset), 32'(255));
    for (int i = 0; i < 600; i++) strobe(i >= 255);
    chk("t4_busy", 32'(busy), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
